// File: rtl/fp_align_stage_pipe.sv
// FP add/sub alignment stage: operand swap, sticky-preserving right shift, one's-complement
// inversion for effective subtraction, base exponent select; 1 or 2 register stages with valid/ready.
module fp_align_stage_pipe #(
  parameter int EXP_W       = 8,
  parameter int FRAC_W      = 23,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [EXP_W-1:0]  exponent1_i,
  input  logic [EXP_W-1:0]  exponent2_i,
  input  logic [FRAC_W:0]   mantissa1_i,
  input  logic [FRAC_W:0]   mantissa2_i,
  input  logic              sign_of_difference_i,
  input  logic              zero_difference_i,
  input  logic [1:0]        compare_i,
  input  logic              eff_operation_i,
  input  logic [EXP_W-1:0]  difference_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FRAC_W+3:0] adder1_o,
  output logic [FRAC_W+3:0] adder2_o,
  output logic              carry_in_o,
  output logic [EXP_W-1:0]  exponent_base_o
);
  localparam int MANT_W = FRAC_W + 1;
  localparam int RND_W  = MANT_W + 3;
  localparam int SH_W   = RND_W - 1;
  localparam int A_W    = 2*RND_W + 2 + EXP_W;
  localparam int B_W    = 2*RND_W + 1 + EXP_W;

  logic [MANT_W-1:0] small_w, big_w;
  logic [SH_W-1:0]   a_w, pre_w, mask_w;
  logic              sticky_w, c1_w, c2_w;
  logic [A_W-1:0]    a_pay_w;
  logic [B_W-1:0]    b_out_w;
  logic              vld_out_w;

  always_comb begin
    small_w  = sign_of_difference_i ? mantissa1_i : mantissa2_i;
    big_w    = sign_of_difference_i ? mantissa2_i : mantissa1_i;
    a_w      = {small_w, 2'b00};
    pre_w    = '0;
    mask_w   = '0;
    sticky_w = |small_w;
    // Shift amount may exceed the datapath: anything past it leaves only sticky.
    if ({{(32-EXP_W){1'b0}}, difference_i} < 32'(SH_W)) begin
      pre_w    = a_w >> difference_i;
      mask_w   = ~({SH_W{1'b1}} << difference_i);
      sticky_w = |(a_w & mask_w);
    end
    c1_w    = eff_operation_i & (~zero_difference_i | (compare_i != 2'b10));
    c2_w    = eff_operation_i & zero_difference_i & (compare_i == 2'b10);
    a_pay_w = {pre_w, sticky_w, big_w, 3'b000, c1_w, c2_w,
               sign_of_difference_i ? exponent2_i : exponent1_i};
  end

  function automatic logic [B_W-1:0] invert_f(input logic [A_W-1:0] p);
    logic [RND_W-1:0] al, nm;
    logic             c1, c2;
    logic [EXP_W-1:0] eb;
    {al, nm, c1, c2, eb} = p;
    return {c1 ? ~al : al, c2 ? ~nm : nm, c1 | c2, eb};
  endfunction

  if (PIPE_STAGES == 1) begin : g_p1
    logic           vld_q, en_w;
    logic [B_W-1:0] b_q;
    assign en_w       = ~vld_q | out_ready_i;
    assign in_ready_o = en_w & ~flush_i;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= 1'b0;
        b_q   <= '0;
      end else begin
        if (flush_i)   vld_q <= 1'b0;
        else if (en_w) vld_q <= in_valid_i;
        if (in_valid_i & in_ready_o) b_q <= invert_f(a_pay_w);
      end
    end
    assign vld_out_w = vld_q;
    assign b_out_w   = b_q;
  end else if (PIPE_STAGES == 2) begin : g_p2
    logic [1:0]     vld_q;
    logic           en0_w, en1_w;
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    // Each stage loads when empty or when its occupant leaves this cycle.
    assign en1_w      = ~vld_q[1] | out_ready_i;
    assign en0_w      = ~vld_q[0] | en1_w;
    assign in_ready_o = en0_w & ~flush_i;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else begin
        if (flush_i) vld_q <= '0;
        else begin
          if (en0_w) vld_q[0] <= in_valid_i;
          if (en1_w) vld_q[1] <= vld_q[0];
        end
        if (in_valid_i & in_ready_o) a_q <= a_pay_w;
        if (en1_w & vld_q[0])        b_q <= invert_f(a_q);
      end
    end
    assign vld_out_w = vld_q[1];
    assign b_out_w   = b_q;
  end else begin : g_bad
    $error("fp_align_stage_pipe: PIPE_STAGES must be 1 or 2");
  end

  assign out_valid_o = vld_out_w;
  assign {adder1_o, adder2_o, carry_in_o, exponent_base_o} = b_out_w;
endmodule

// File: tb/tb_fp_align_stage_pipe.sv
// Bench for fp_align_stage_pipe: PIPE_STAGES=1 and 2 instances share stimulus, each with its own scoreboard.
module tb_fp_align_stage_pipe;
  localparam int EW = 8;
  localparam int RW = 27;
  localparam int BW = 2*RW + 1 + EW;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [EW-1:0] e1, e2, dif;
  logic [23:0]   m1, m2;
  logic          sod, zd, eff;
  logic [1:0]    cmp;

  logic          ir1, ov1, ci1, ir2, ov2, ci2;
  logic [RW-1:0] a1_1, a2_1, a1_2, a2_2;
  logic [EW-1:0] eb1, eb2;

  int total = 0, bad = 0, acc1 = 0, acc2 = 0;
  logic [BW-1:0] q1[$], q2[$];

  always #5 clk = ~clk;

  fp_align_stage_pipe #(.EXP_W(8), .FRAC_W(23), .PIPE_STAGES(1)) u_p1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
    .exponent1_i(e1), .exponent2_i(e2), .mantissa1_i(m1), .mantissa2_i(m2),
    .sign_of_difference_i(sod), .zero_difference_i(zd), .compare_i(cmp),
    .eff_operation_i(eff), .difference_i(dif), .out_valid_o(ov1), .out_ready_i(out_ready),
    .adder1_o(a1_1), .adder2_o(a2_1), .carry_in_o(ci1), .exponent_base_o(eb1));

  fp_align_stage_pipe #(.EXP_W(8), .FRAC_W(23), .PIPE_STAGES(2)) u_p2 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir2),
    .exponent1_i(e1), .exponent2_i(e2), .mantissa1_i(m1), .mantissa2_i(m2),
    .sign_of_difference_i(sod), .zero_difference_i(zd), .compare_i(cmp),
    .eff_operation_i(eff), .difference_i(dif), .out_valid_o(ov2), .out_ready_i(out_ready),
    .adder1_o(a1_2), .adder2_o(a2_2), .carry_in_o(ci2), .exponent_base_o(eb2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model straight from the behavioural description.
  function automatic logic [BW-1:0] model();
    logic [23:0] sm, bg;
    logic [25:0] av, pre;
    logic [26:0] al, nm;
    logic        st, c1, c2;
    sm = sod ? m1 : m2;
    bg = sod ? m2 : m1;
    av = {sm, 2'b00};
    st = 1'b0;
    if (int'(dif) >= 26) begin
      pre = '0;
      st  = |sm;
    end else begin
      pre = av >> dif;
      for (int i = 0; i < 26; i++) if (i < int'(dif)) st |= av[i];
    end
    al = {pre, st};
    nm = {bg, 3'b000};
    c1 = 1'b0; c2 = 1'b0;
    if (eff) begin
      if (!zd)               c1 = 1'b1;
      else if (cmp == 2'b10) c2 = 1'b1;
      else                   c1 = 1'b1;
    end
    return {c1 ? ~al : al, c2 ? ~nm : nm, c1 | c2, sod ? e2 : e1};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete(); q2.delete();
    end else begin
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("p1_spurious", 1, 0);
        else chk("p1_data", {a1_1, a2_1, ci1, eb1}, q1.pop_front());
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) chk("p2_spurious", 1, 0);
        else chk("p2_data", {a1_2, a2_2, ci2, eb2}, q2.pop_front());
      end
      if (flush) begin q1.delete(); q2.delete(); end
      if (in_valid && ir1) begin q1.push_back(model()); acc1++; end
      if (in_valid && ir2) begin q2.push_back(model()); acc2++; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input logic [7:0] x1, x2, input logic [23:0] y1, y2,
                         input logic s, z, input logic [1:0] c, input logic ef, input logic [7:0] d);
    e1 = x1; e2 = x2; m1 = y1; m2 = y2; sod = s; zd = z; cmp = c; eff = ef; dif = d;
  endtask

  task automatic rand_vec();
    e1 = 8'($urandom); e2 = 8'($urandom);
    m1 = ($urandom_range(0, 7) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
    m2 = ($urandom_range(0, 7) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
    sod = 1'($urandom); zd = 1'($urandom); cmp = 2'($urandom); eff = 1'($urandom);
    dif = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) step();
    chk("drain_p1", q1.size(), 0);
    chk("drain_p2", q2.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_ov1", ov1, 0); chk("rst_ov2", ov2, 0);
    chk("rst_a1", a1_2, 0); chk("rst_eb", eb1, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_ir1", ir1, 1); chk("rst_ir2", ir2, 1);
    step();

    // Basic add, with latency per instance.
    set_vec(8'h80, 8'h7E, 24'h800000, 24'hC00000, 0, 0, 2'b00, 0, 8'd2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_p1_v", ov1, 1); chk("lat_p2_v", ov2, 0);
    chk("add_a1", a1_1, 27'h1800000); chk("add_a2", a2_1, 27'h4000000);
    chk("add_ci", ci1, 0); chk("add_eb", eb1, 8'h80);
    step();
    chk("lat_p2_v2", ov2, 1); chk("add_p2_a1", a1_2, 27'h1800000);
    chk("lat_p1_gone", ov1, 0);
    drain();

    // Back-to-back directed corners: sticky, zero shift, saturation, subtraction.
    in_valid = 1'b1;
    set_vec(8'h90, 8'h8D, 24'h800000, 24'h800001, 0, 0, 2'b01, 0, 8'd3);   step();
    set_vec(8'h90, 8'h90, 24'h800000, 24'h800001, 0, 1, 2'b10, 0, 8'd0);   step();
    set_vec(8'hA0, 8'h78, 24'hF00000, 24'h800000, 0, 0, 2'b01, 0, 8'd40);  step();
    set_vec(8'hFF, 8'h00, 24'hF00000, 24'h800000, 0, 0, 2'b01, 0, 8'd255); step();
    set_vec(8'hFF, 8'h00, 24'hF00000, 24'h000000, 0, 0, 2'b01, 0, 8'd255); step();
    set_vec(8'h85, 8'h85, 24'h900000, 24'hA00000, 1, 1, 2'b10, 1, 8'd0);   step();
    set_vec(8'h85, 8'h85, 24'hA00000, 24'hA00000, 0, 1, 2'b00, 1, 8'd0);   step();
    set_vec(8'h70, 8'h85, 24'hABCDEF, 24'hC00000, 1, 0, 2'b10, 1, 8'd21);  step();
    set_vec(8'h85, 8'h60, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 2'b01, 1, 8'd25);  step();
    set_vec(8'h85, 8'h60, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 2'b01, 1, 8'd26);  step();
    drain();

    // Backpressure: capacity equals stage count.
    acc1 = 0; acc2 = 0; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_vec(8'(8'h10 + i), 8'h08, 24'(24'h800000 + i), 24'hC00003, 0, 0, 2'b01, 0, 8'(i));
      step();
    end
    chk("bp_acc_p1", acc1, 1); chk("bp_acc_p2", acc2, 2);
    chk("bp_ir1", ir1, 0); chk("bp_ir2", ir2, 0);
    chk("bp_ov1", ov1, 1); chk("bp_ov2", ov2, 1);
    drain();

    // Flush with full pipes: entries dropped, flush-cycle input refused.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_vec(); step(); end
    flush = 1'b1; rand_vec();
    #1;
    chk("fl_ir1", ir1, 0); chk("fl_ir2", ir2, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ov1", ov1, 0); chk("fl_ov2", ov2, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("fl_quiet1", ov1, 0); chk("fl_quiet2", ov2, 0);

    // Asynchronous reset with full pipes.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_vec(); step(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov1", ov1, 0); chk("ar_ov2", ov2, 0);
    chk("ar_a1", a1_2, 0); chk("ar_a2", a2_1, 0); chk("ar_eb", eb2, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ar_quiet1", ov1, 0); chk("ar_quiet2", ov2, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_vec();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
